// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: word width, FSM encodings and the round-constant table.
package aes_pkg;

  localparam int AES_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: latches the cipher key, then writes one expanded word per clock
// through a single shared SubWord datapath until all (nr+1) round keys are present.
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [nk*32-1:0]       key,
  output logic [0:(nr+1)*128-1]  w,
  output logic                   busy,
  output logic                   w_valid
);

  localparam int NW = 4 * (nr + 1);
  localparam int IW = $clog2(NW);
  localparam int PW = (nk > 1) ? $clog2(nk) : 1;
  localparam int RW = 4;

  logic [AES_WORD_W-1:0] r_words [NW];
  logic [IW-1:0]         r_idx;
  logic [PW-1:0]         r_phase;   // r_idx mod nk, avoids a divider for nk=6
  logic [RW-1:0]         r_rnd;     // r_idx / nk, selects rcon
  state_t                r_state;

  logic [AES_WORD_W-1:0] w_prev;
  logic [AES_WORD_W-1:0] w_back;
  logic [AES_WORD_W-1:0] w_sub_in;
  logic [AES_WORD_W-1:0] w_sub_out;
  logic [AES_WORD_W-1:0] w_t;
  logic [AES_WORD_W-1:0] w_new;

  assign w_prev   = r_words[r_idx - IW'(1)];
  assign w_back   = r_words[r_idx - IW'(nk)];
  assign w_sub_in = (r_phase == PW'(0)) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte(w_sub_in[b*8 +: 8]),
      .o_byte(w_sub_out[b*8 +: 8])
    );
  end

  // Select the transformed previous word fed into the XOR with word[idx-nk].
  always_comb begin
    w_t = w_prev;
    if (r_phase == PW'(0)) begin
      w_t = w_sub_out ^ {rcon(r_rnd), 24'h000000};
    end else if ((nk > 6) && (int'(r_phase) == 4)) begin
      w_t = w_sub_out;
    end else begin
      w_t = w_prev;
    end
  end

  assign w_new = w_back ^ w_t;

  for (genvar j = 0; j < NW; j++) begin : g_pack
    assign w[j*32 +: 32] = r_words[j];
  end

  // Schedule FSM: key latch, word-per-cycle expansion and completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) r_words[i] <= '0;
      r_idx   <= '0;
      r_phase <= '0;
      r_rnd   <= '0;
      busy    <= 1'b0;
      w_valid <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int i = 0; i < nk; i++) r_words[i] <= key[(nk-1-i)*32 +: 32];
            r_idx   <= IW'(nk);
            r_phase <= '0;
            r_rnd   <= RW'(1);
            busy    <= 1'b1;
            w_valid <= 1'b0;
            r_state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          r_words[r_idx] <= w_new;
          if (r_idx == IW'(NW - 1)) begin
            busy    <= 1'b0;
            w_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
            if (r_phase == PW'(nk - 1)) begin
              r_phase <= '0;
              r_rnd   <= r_rnd + RW'(1);
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          w_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq against FIPS-197 Appendix A / C key schedules.
module tb_key_expansion_seq;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst;
  logic start128, start192, start256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [0:1407] w128;
  logic [0:1663] w192;
  logic [0:1919] w256;
  logic busy128, busy192, busy256;
  logic wv128, wv192, wv256;

  int n_checks = 0;
  int n_err    = 0;
  int n;

  always #5 clk = ~clk;

  key_expansion_seq #(.nk(4), .nr(10)) d128 (
    .clk(clk), .reset(rst), .start(start128), .key(key128),
    .w(w128), .busy(busy128), .w_valid(wv128));
  key_expansion_seq #(.nk(6), .nr(12)) d192 (
    .clk(clk), .reset(rst), .start(start192), .key(key192),
    .w(w192), .busy(busy192), .w_valid(wv192));
  key_expansion_seq #(.nk(8), .nr(14)) d256 (
    .clk(clk), .reset(rst), .start(start256), .key(key256),
    .w(w256), .busy(busy256), .w_valid(wv256));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd128(input int j);
    return w128[j*32 +: 32];
  endfunction
  function automatic logic [31:0] wd192(input int j);
    return w192[j*32 +: 32];
  endfunction
  function automatic logic [31:0] wd256(input int j);
    return w256[j*32 +: 32];
  endfunction

  // Start an AES-128 expansion and count edges until w_valid, with optional disturbances.
  task automatic go128(input int pulse_a, input int pulse_b, input int rst_at,
                       input bit toggle, input logic [127:0] alt,
                       input bit chk_stale, input logic [31:0] stale_w4,
                       output int cnt);
    @(negedge clk);
    start128 = 1'b1;
    @(posedge clk);
    #1;
    start128 = 1'b0;
    chk("start_wv_low", {127'b0, wv128}, 128'd0);
    chk("start_busy", {127'b0, busy128}, 128'd1);
    if (chk_stale) begin
      chk("restart_w0", {96'b0, wd128(0)}, {96'b0, key128[127:96]});
      chk("stale_w4", {96'b0, wd128(4)}, {96'b0, stale_w4});
    end
    cnt = 0;
    while (cnt < 100) begin
      if (toggle) key128 = cnt[0] ? alt : ~alt;
      start128 = ((cnt + 1) == pulse_a) || ((cnt + 1) == pulse_b);
      @(posedge clk);
      cnt++;
      #1;
      start128 = 1'b0;
      if (cnt == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk("midrst_w", {127'b0, |w128}, 128'd0);
        chk("midrst_busy", {127'b0, busy128}, 128'd0);
        chk("midrst_wv", {127'b0, wv128}, 128'd0);
        return;
      end
      if (wv128) break;
    end
  endtask

  task automatic go_wide(input int sel, output int cnt);
    @(negedge clk);
    if (sel == 0) start192 = 1'b1;
    else start256 = 1'b1;
    @(posedge clk);
    #1;
    start192 = 1'b0;
    start256 = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if ((sel == 0) ? wv192 : wv256) break;
    end
  endtask

  initial begin
    rst = 1'b1;
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    key128 = KEY_A1;
    key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w128", {127'b0, |w128}, 128'd0);
    chk("rst_busy128", {127'b0, busy128}, 128'd0);
    chk("rst_wv128", {127'b0, wv128}, 128'd0);
    chk("rst_wv256", {127'b0, wv256}, 128'd0);
    @(negedge clk) rst = 1'b0;

    // AES-128 FIPS-197 A.1
    go128(0, 0, 0, 1'b0, '0, 1'b0, 32'h0, n);
    chk("a128_latency", n, 40);
    chk("a128_rk0", w128[0:127], KEY_A1);
    chk("a128_w4", {96'b0, wd128(4)}, {96'b0, 32'ha0fafe17});
    chk("a128_w5", {96'b0, wd128(5)}, {96'b0, 32'h88542cb1});
    chk("a128_rk10", w128[1280:1407], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a128_busy_done", {127'b0, busy128}, 128'd0);

    // start pulses while busy are ignored
    go128(5, 30, 0, 1'b0, '0, 1'b0, 32'h0, n);
    chk("ign_latency", n, 40);
    chk("ign_w43", {96'b0, wd128(43)}, {96'b0, 32'hb6630ca6});

    // restart from DONE with a new key; word 4 stays stale until rewritten
    @(negedge clk) key128 = KEY_C1;
    go128(0, 0, 0, 1'b0, '0, 1'b1, 32'ha0fafe17, n);
    chk("c1_latency", n, 40);
    chk("c1_w4", {96'b0, wd128(4)}, {96'b0, 32'hd6aa74fd});
    chk("c1_rk10", w128[1280:1407], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // asynchronous reset mid-expansion, then a clean re-expansion
    @(negedge clk) key128 = KEY_A1;
    go128(0, 0, 20, 1'b0, '0, 1'b0, 32'h0, n);
    @(negedge clk) rst = 1'b0;
    go128(0, 0, 0, 1'b0, '0, 1'b0, 32'h0, n);
    chk("post_rst_latency", n, 40);
    chk("post_rst_w4", {96'b0, wd128(4)}, {96'b0, 32'ha0fafe17});
    chk("post_rst_w43", {96'b0, wd128(43)}, {96'b0, 32'hb6630ca6});

    // key toggling after the start edge must not disturb the latched key
    @(negedge clk) key128 = KEY_C1;
    go128(0, 0, 0, 1'b1, KEY_A1, 1'b0, 32'h0, n);
    chk("tog_latency", n, 40);
    chk("tog_rk0", w128[0:127], KEY_C1);
    chk("tog_w43", {96'b0, wd128(43)}, {96'b0, 32'h4d2b30c5});

    // AES-192 FIPS-197 A.2
    go_wide(0, n);
    chk("a192_latency", n, 46);
    chk("a192_w6", {96'b0, wd192(6)}, {96'b0, 32'hfe0c91f7});
    chk("a192_w51", {96'b0, wd192(51)}, {96'b0, 32'h01002202});
    chk("a192_busy", {127'b0, busy192}, 128'd0);

    // AES-256 FIPS-197 A.3; word 12 exercises the extra SubWord step
    go_wide(1, n);
    chk("a256_latency", n, 52);
    chk("a256_w8", {96'b0, wd256(8)}, {96'b0, 32'h9ba35411});
    chk("a256_w9", {96'b0, wd256(9)}, {96'b0, 32'h8e6925af});
    chk("a256_w12", {96'b0, wd256(12)}, {96'b0, 32'ha8b09c1a});
    chk("a256_w59", {96'b0, wd256(59)}, {96'b0, 32'h706c631e});
    chk("a256_busy", {127'b0, busy256}, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
